// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt controller: ExcCode values,
// exc_vec bit positions, FSM states, winner/badvaddr selectors and the
// default exception vector address.
package exc_pkg;

  // Default exception/interrupt entry vector
  localparam logic [31:0] EXC_ENTER_ADDR_DEF = 32'hBFC0_0380;

  // Bit positions inside exc_vec
  localparam int EXC_BIT_FETCH = 6;
  localparam int EXC_BIT_RI    = 5;
  localparam int EXC_BIT_SYS   = 4;
  localparam int EXC_BIT_BP    = 3;
  localparam int EXC_BIT_OV    = 2;
  localparam int EXC_BIT_RADDR = 1;
  localparam int EXC_BIT_WADDR = 0;

  // CP0 Cause.ExcCode values
  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0A;
  localparam logic [4:0] CODE_OV   = 5'h0C;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  // Arbitration winner, highest priority first
  typedef enum logic [3:0] {
    WIN_NONE  = 4'd0,
    WIN_INT   = 4'd1,
    WIN_FETCH = 4'd2,
    WIN_RI    = 4'd3,
    WIN_SYS   = 4'd4,
    WIN_BP    = 4'd5,
    WIN_OV    = 4'd6,
    WIN_RADDR = 4'd7,
    WIN_WADDR = 4'd8,
    WIN_ERET  = 4'd9
  } exc_win_e;

  // Source of the bad virtual address
  typedef enum logic [1:0] {
    BV_NONE = 2'd0,
    BV_PC   = 2'd1,
    BV_DM   = 2'd2
  } bv_sel_e;

  // EPC of the faulting instruction: the branch when in a delay slot
  function automatic logic [31:0] victim_pc(input logic [31:0] pc, input logic in_ds);
    logic [31:0] res;
    if (in_ds) begin
      res = pc - 32'd4;
    end else begin
      res = pc;
    end
    return res;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority arbiter for the exception sources of the WB instruction.
// Order: interrupt, fetch_error, inst_reserved, syscall, break, overflow,
// raddr_error, waddr_error, eret. Purely combinational.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       int_q,
  input  logic [6:0] exc_vec,
  input  logic       eret,
  output exc_win_e   win,
  output logic [4:0] code,
  output bv_sel_e    bv_sel
);

  // Pick the single highest-priority source and its ExcCode / badvaddr source
  always_comb begin
    win    = WIN_NONE;
    code   = CODE_INT;
    bv_sel = BV_NONE;
    if (int_q) begin
      win  = WIN_INT;
      code = CODE_INT;
    end else if (exc_vec[EXC_BIT_FETCH]) begin
      win    = WIN_FETCH;
      code   = CODE_ADEL;
      bv_sel = BV_PC;
    end else if (exc_vec[EXC_BIT_RI]) begin
      win  = WIN_RI;
      code = CODE_RI;
    end else if (exc_vec[EXC_BIT_SYS]) begin
      win  = WIN_SYS;
      code = CODE_SYS;
    end else if (exc_vec[EXC_BIT_BP]) begin
      win  = WIN_BP;
      code = CODE_BP;
    end else if (exc_vec[EXC_BIT_OV]) begin
      win  = WIN_OV;
      code = CODE_OV;
    end else if (exc_vec[EXC_BIT_RADDR]) begin
      win    = WIN_RADDR;
      code   = CODE_ADEL;
      bv_sel = BV_DM;
    end else if (exc_vec[EXC_BIT_WADDR]) begin
      win    = WIN_WADDR;
      code   = CODE_ADES;
      bv_sel = BV_DM;
    end else if (eret) begin
      win  = WIN_ERET;
      code = CODE_INT;
    end else begin
      win = WIN_NONE;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller at WB. On a trigger it flushes younger
// instructions and commits CP0 for one cycle (FLUSH), then holds a fetch
// redirect until acknowledged (REDIRECT). All outputs are flops.
// Optional macro EXC_CTRL_STATS_EN adds a taken-exception counter on
// exc_count; without it exc_count is tied to zero.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_ENTER_ADDR = EXC_ENTER_ADDR_DEF
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [6:0]  exc_vec,
  input  logic        eret,
  input  logic        delay_slot,
  input  logic [31:0] wb_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] epc,
  input  logic [7:0]  int_pending,
  input  logic [7:0]  status_im,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        redirect_ack,
  output logic        cancel,
  output logic        cp0_commit,
  output logic [4:0]  exc_code,
  output logic        exc_bd,
  output logic [31:0] exc_epc,
  output logic        set_exl,
  output logic        clr_exl,
  output logic        badvaddr_we,
  output logic [31:0] exc_badvaddr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [31:0] exc_count
);

  exc_state_e  state_r, state_nxt_s;
  logic        int_q_r, int_nxt_s;
  logic        trigger_s;
  exc_win_e    win_s;
  logic [4:0]  code_s;
  bv_sel_e     bv_sel_s;
  logic        is_eret_s;
  logic        bv_we_s;
  logic [31:0] bv_addr_s;
  logic        kind_eret_r;
  logic [31:0] epc_r;

  logic        cancel_r, cp0_commit_r, exc_bd_r, set_exl_r, clr_exl_r;
  logic        badvaddr_we_r, redirect_valid_r, busy_r;
  logic [4:0]  exc_code_r;
  logic [31:0] exc_epc_r, exc_badvaddr_r, redirect_pc_r;

  exc_prio_enc u_prio (
    .int_q   (int_q_r),
    .exc_vec (exc_vec),
    .eret    (eret),
    .win     (win_s),
    .code    (code_s),
    .bv_sel  (bv_sel_s)
  );

  // Masked/enabled interrupt request and trigger qualification
  always_comb begin
    int_nxt_s = (|(int_pending & status_im)) & status_ie & ~status_exl;
    trigger_s = (state_r == ST_IDLE) & wb_valid & (int_q_r | (|exc_vec) | eret);
    is_eret_s = (win_s == WIN_ERET);
  end

  // Bad virtual address source selection
  always_comb begin
    bv_addr_s = 32'h0000_0000;
    bv_we_s   = 1'b0;
    case (bv_sel_s)
      BV_PC: begin
        bv_addr_s = wb_pc;
        bv_we_s   = 1'b1;
      end
      BV_DM: begin
        bv_addr_s = dm_addr;
        bv_we_s   = 1'b1;
      end
      default: begin
        bv_addr_s = 32'h0000_0000;
        bv_we_s   = 1'b0;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trigger_s) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        state_nxt_s = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REDIRECT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered interrupt request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      int_q_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      int_q_r <= int_nxt_s;
    end
  end

  // Capture kind and EPC at trigger for use by the later redirect
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kind_eret_r <= 1'b0;
      epc_r       <= 32'h0000_0000;
    end else if (trigger_s) begin
      kind_eret_r <= is_eret_s;
      epc_r       <= epc;
    end else begin
      kind_eret_r <= kind_eret_r;
      epc_r       <= epc_r;
    end
  end

  // CP0 commit fields: loaded at trigger so they are live exactly in FLUSH
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cancel_r       <= 1'b0;
      cp0_commit_r   <= 1'b0;
      exc_code_r     <= 5'h00;
      exc_bd_r       <= 1'b0;
      exc_epc_r      <= 32'h0000_0000;
      set_exl_r      <= 1'b0;
      clr_exl_r      <= 1'b0;
      badvaddr_we_r  <= 1'b0;
      exc_badvaddr_r <= 32'h0000_0000;
    end else if (trigger_s) begin
      cancel_r       <= 1'b1;
      cp0_commit_r   <= 1'b1;
      exc_code_r     <= code_s;
      exc_bd_r       <= delay_slot;
      exc_epc_r      <= victim_pc(wb_pc, delay_slot);
      set_exl_r      <= ~is_eret_s;
      clr_exl_r      <= is_eret_s;
      badvaddr_we_r  <= bv_we_s;
      exc_badvaddr_r <= bv_addr_s;
    end else begin
      cancel_r       <= 1'b0;
      cp0_commit_r   <= 1'b0;
      exc_code_r     <= 5'h00;
      exc_bd_r       <= 1'b0;
      exc_epc_r      <= 32'h0000_0000;
      set_exl_r      <= 1'b0;
      clr_exl_r      <= 1'b0;
      badvaddr_we_r  <= 1'b0;
      exc_badvaddr_r <= 32'h0000_0000;
    end
  end

  // Redirect request and busy, derived from the upcoming state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'h0000_0000;
      busy_r           <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      if (state_nxt_s == ST_REDIRECT) begin
        redirect_valid_r <= 1'b1;
        redirect_pc_r    <= kind_eret_r ? epc_r : EXC_ENTER_ADDR;
      end else begin
        redirect_valid_r <= 1'b0;
        redirect_pc_r    <= 32'h0000_0000;
      end
    end
  end

`ifdef EXC_CTRL_STATS_EN
  logic [31:0] count_r;

  // Count each FLUSH of exception/interrupt kind; wraps naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= 32'h0000_0000;
    end else if ((state_r == ST_FLUSH) && !kind_eret_r) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign exc_count = count_r;
`else
  assign exc_count = 32'h0000_0000;
`endif

  assign cancel         = cancel_r;
  assign cp0_commit     = cp0_commit_r;
  assign exc_code       = exc_code_r;
  assign exc_bd         = exc_bd_r;
  assign exc_epc        = exc_epc_r;
  assign set_exl        = set_exl_r;
  assign clr_exl        = clr_exl_r;
  assign badvaddr_we    = badvaddr_we_r;
  assign exc_badvaddr   = exc_badvaddr_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized
// transactions compared against a table-driven priority model.
module tb_exc_ctrl;

  logic        clk;
  logic        resetn;
  logic        wb_valid;
  logic [6:0]  exc_vec;
  logic        eret;
  logic        delay_slot;
  logic [31:0] wb_pc, dm_addr, epc;
  logic [7:0]  int_pending, status_im;
  logic        status_ie, status_exl;
  logic        redirect_ack;
  logic        cancel, cp0_commit, exc_bd, set_exl, clr_exl, badvaddr_we;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr, redirect_pc, exc_count;
  logic        redirect_valid, busy;

  int n_checks;
  int n_errors;
  logic [31:0] model_cnt;

  // ExcCode by priority rank: int, fetch, ri, sys, bp, ov, raddr, waddr, eret
  logic [4:0] code_tab [0:8];

  exc_ctrl dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .exc_vec(exc_vec),
    .eret(eret), .delay_slot(delay_slot), .wb_pc(wb_pc), .dm_addr(dm_addr),
    .epc(epc), .int_pending(int_pending), .status_im(status_im),
    .status_ie(status_ie), .status_exl(status_exl), .redirect_ack(redirect_ack),
    .cancel(cancel), .cp0_commit(cp0_commit), .exc_code(exc_code),
    .exc_bd(exc_bd), .exc_epc(exc_epc), .set_exl(set_exl), .clr_exl(clr_exl),
    .badvaddr_we(badvaddr_we), .exc_badvaddr(exc_badvaddr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag);
`ifdef EXC_CTRL_STATS_EN
    check_val(tag, exc_count, model_cnt);
`else
    check_val(tag, exc_count, 32'h0);
`endif
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_cancel"}, {31'h0, cancel}, 32'h0);
    check_val({tag, "_commit"}, {31'h0, cp0_commit}, 32'h0);
    check_val({tag, "_code"}, {27'h0, exc_code}, 32'h0);
    check_val({tag, "_epc"}, exc_epc, 32'h0);
    check_val({tag, "_bv"}, exc_badvaddr, 32'h0);
    check_val({tag, "_exl"}, {30'h0, set_exl, clr_exl}, 32'h0);
    check_val({tag, "_rv"}, {31'h0, redirect_valid}, 32'h0);
    check_val({tag, "_rpc"}, redirect_pc, 32'h0);
    check_val({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // One WB instruction presented after interrupt inputs have settled
  task automatic do_txn(input logic [7:0] ip, input logic [7:0] im, input logic ie,
                        input logic exl, input logic [6:0] ev, input logic er,
                        input logic ds, input logic [31:0] pc, input logic [31:0] da,
                        input logic [31:0] ep, input int hold);
    logic        int_exp;
    logic [8:0]  flags;
    int          win;
    logic        ker;
    logic        bvwe;
    logic [31:0] bva;
    logic [31:0] rpc;
    int_pending = ip; status_im = im; status_ie = ie; status_exl = exl;
    wb_valid = 1'b0; redirect_ack = 1'b0;
    exc_vec = ev; eret = er;
    step();
    check_val("idle_no_trig", {31'h0, busy}, 32'h0);
    wb_valid = 1'b1; exc_vec = ev; eret = er; delay_slot = ds;
    wb_pc = pc; dm_addr = da; epc = ep;
    int_exp = ((ip & im) != 8'h00) && ie && !exl;
    flags = {int_exp, ev, er};
    win = -1;
    for (int i = 8; i >= 0; i--) begin
      if (flags[i] && win < 0) win = 8 - i;
    end
    step();
    wb_valid = 1'b0;
    epc = $urandom;
    if (win < 0) begin
      check_quiet("no_trig");
    end else begin
      ker  = (win == 8);
      bvwe = (win == 1) || (win == 6) || (win == 7);
      bva  = (win == 1) ? pc : (bvwe ? da : 32'h0);
      rpc  = ker ? ep : 32'hBFC0_0380;
      check_val("fl_cancel", {31'h0, cancel}, 32'h1);
      check_val("fl_commit", {31'h0, cp0_commit}, 32'h1);
      check_val("fl_code", {27'h0, exc_code}, {27'h0, code_tab[win]});
      check_val("fl_bd", {31'h0, exc_bd}, {31'h0, ds});
      check_val("fl_epc", exc_epc, ds ? pc - 32'd4 : pc);
      check_val("fl_set_exl", {31'h0, set_exl}, {31'h0, !ker});
      check_val("fl_clr_exl", {31'h0, clr_exl}, {31'h0, ker});
      check_val("fl_bv_we", {31'h0, badvaddr_we}, {31'h0, bvwe});
      check_val("fl_bv", exc_badvaddr, bva);
      check_val("fl_rv", {31'h0, redirect_valid}, 32'h0);
      check_val("fl_busy", {31'h0, busy}, 32'h1);
      if (!ker) model_cnt = model_cnt + 32'd1;
      // an ack while flushing must be ignored
      redirect_ack = $urandom_range(0, 1);
      step();
      for (int k = 0; k <= hold; k++) begin
        check_val("rd_valid", {31'h0, redirect_valid}, 32'h1);
        check_val("rd_pc", redirect_pc, rpc);
        check_val("rd_busy", {31'h0, busy}, 32'h1);
        check_val("rd_commit", {31'h0, cp0_commit}, 32'h0);
        check_val("rd_cancel", {31'h0, cancel}, 32'h0);
        redirect_ack = (k == hold);
        wb_valid = (k != hold);
        exc_vec = 7'h10;
        epc = $urandom;
        step();
      end
      redirect_ack = 1'b0;
      wb_valid = 1'b0;
      check_val("ack_idle_busy", {31'h0, busy}, 32'h0);
      check_val("ack_idle_rv", {31'h0, redirect_valid}, 32'h0);
      check_val("ack_idle_cancel", {31'h0, cancel}, 32'h0);
    end
    step();
    check_count("count");
  endtask

  task automatic reset_mid_redirect();
    status_ie = 1'b0; wb_valid = 1'b1; exc_vec = 7'h10; eret = 1'b0;
    delay_slot = 1'b0; wb_pc = 32'hBFC0_0100;
    step();
    wb_valid = 1'b0;
    step();
    check_val("pre_rst_rv", {31'h0, redirect_valid}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    model_cnt = 32'h0;
    check_quiet("rst_now");
    check_count("rst_now_count");
    step();
    check_quiet("rst_held");
    resetn = 1'b1;
    step();
    step();
  endtask

  logic [6:0] rev;
  logic [7:0] rip, rim;

  initial begin
    code_tab[0] = 5'h00; code_tab[1] = 5'h04; code_tab[2] = 5'h0A;
    code_tab[3] = 5'h08; code_tab[4] = 5'h09; code_tab[5] = 5'h0C;
    code_tab[6] = 5'h04; code_tab[7] = 5'h05; code_tab[8] = 5'h00;
    n_checks = 0; n_errors = 0; model_cnt = 32'h0;
    resetn = 1'b0; wb_valid = 1'b0; exc_vec = 7'h00; eret = 1'b0;
    delay_slot = 1'b0; wb_pc = 32'h0; dm_addr = 32'h0; epc = 32'h0;
    int_pending = 8'h00; status_im = 8'h00; status_ie = 1'b0; status_exl = 1'b0;
    redirect_ack = 1'b0;
    #1;
    check_quiet("reset");
    check_count("reset_count");
    step();
    step();
    resetn = 1'b1;
    step();

    // syscall, no delay slot
    do_txn(8'h00, 8'h00, 1'b0, 1'b0, 7'h10, 1'b0, 1'b0, 32'hBFC0_0100, 32'h0, 32'h0, 2);
    // raddr error in a delay slot
    do_txn(8'h00, 8'h00, 1'b0, 1'b0, 7'h02, 1'b0, 1'b1, 32'hBFC0_0204, 32'h8000_0003, 32'h0, 1);
    // overflow beats eret; then eret alone
    do_txn(8'h00, 8'h00, 1'b0, 1'b0, 7'h04, 1'b1, 1'b0, 32'hBFC0_0300, 32'h0, 32'hBFC0_0500, 0);
    do_txn(8'h00, 8'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 32'hBFC0_0300, 32'h0, 32'hBFC0_0500, 0);
    // interrupt taken, then masked by EXL
    do_txn(8'h80, 8'h80, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 32'hBFC0_0400, 32'h0, 32'h0, 0);
    do_txn(8'h80, 8'h80, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0, 32'hBFC0_0400, 32'h0, 32'h0, 0);
    // long ack stall, fetch error with wraparound EPC in delay slot
    do_txn(8'h00, 8'h00, 1'b0, 1'b0, 7'h40, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 32'h0, 5);
    // waddr error
    do_txn(8'h00, 8'h00, 1'b0, 1'b0, 7'h01, 1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEE1, 32'h0, 0);

    reset_mid_redirect();

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: rev = 7'h00;
        1: rev = 7'(1 << $urandom_range(0, 6));
        default: rev = 7'($urandom);
      endcase
      rip = 8'($urandom);
      rim = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      do_txn(rip, rim, 1'($urandom), 1'($urandom), rev, 1'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom, $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_ENTER_ADDR, default 32'hBFC00380, shall be the exception/interrupt vector address.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 wb_valid  input  1  WB holds a valid instruction this cycle.
REQ-005 exc_vec  input  7  per-instruction exception flags: [6]fetch_error [5]inst_reserved [4]syscall [3]break [2]overflow [1]raddr_error [0]waddr_error.
REQ-006 eret  input  1  WB instruction is ERET.
REQ-007 delay_slot  input  1  WB instruction is in a branch delay slot.
REQ-008 wb_pc, dm_addr, epc  input  32 each  WB PC, data address, current CP0 EPC.
REQ-009 int_pending  input  8  Cause.IP; status_im  input  8  Status.IM; status_ie, status_exl  input  1 each.
REQ-010 redirect_ack  input  1  fetch stage accepts redirect.
REQ-011 cancel  output  1  flush all younger in-flight instructions.
REQ-012 cp0_commit  output  1  one-cycle strobe to write CP0; with exc_code 5, exc_bd 1, exc_epc 32, set_exl 1, clr_exl 1, badvaddr_we 1, exc_badvaddr 32.
REQ-013 redirect_valid  output  1; redirect_pc  output  32  new fetch PC.
REQ-014 busy  output  1  high whenever state is not IDLE; front end shall stall.
REQ-015 exc_count  output  32  taken exceptions/interrupts (see Configuration).

Function
REQ-016 FSM states IDLE, FLUSH, REDIRECT; IDLE->FLUSH on trigger; FLUSH->REDIRECT unconditionally after one cycle; REDIRECT->IDLE on cycle redirect_ack=1.
REQ-017 int_q register: next = |(int_pending & status_im) & status_ie & ~status_exl; only int_q (never the raw value) shall trigger.
REQ-018 Trigger = IDLE & wb_valid & (int_q | |exc_vec | eret); no trigger when wb_valid=0.
REQ-019 Priority, highest first: int_q, fetch_error, inst_reserved, syscall, break, overflow, raddr_error, waddr_error, eret; only the winner is recorded.
REQ-020 ExcCode: int 0x00, fetch_error 0x04, inst_reserved 0x0A, syscall 0x08, break 0x09, overflow 0x0C, raddr_error 0x04, waddr_error 0x05.
REQ-021 At trigger, capture into registers: code, exc_bd=delay_slot, exc_epc = delay_slot ? wb_pc-4 : wb_pc (mod 2^32), kind (exc/eret), epc.
REQ-022 exc_badvaddr = wb_pc for fetch_error, dm_addr for raddr/waddr_error; badvaddr_we=1 only for those three winners.
REQ-023 In FLUSH (exactly one cycle, trigger+1): cancel=1, cp0_commit=1; set_exl=1 for exception/interrupt, clr_exl=1 for eret; never both.
REQ-024 In REDIRECT (from trigger+2): redirect_valid=1, redirect_pc = EXC_ENTER_ADDR for exception/interrupt, captured epc for eret; held stable until acked; ack in same cycle as entry honoured.
REQ-025 Triggers and redirect_ack while not in the state consuming them shall be ignored; all cp0 output fields shall be 0 outside FLUSH.

Reset
REQ-026 On resetn=0 (any state, mid-operation): state IDLE, int_q 0, captured registers 0, exc_count 0; all outputs 0 immediately and while held.
REQ-027 First trigger is possible in the second rising edge after resetn deasserts.

Configuration
REQ-028 Macro EXC_CTRL_STATS_EN defined: exc_count increments by 1 per FLUSH of exception/interrupt kind (not eret), wraps 0xFFFFFFFF->0.
REQ-029 Macro undefined: no counter register; exc_count tied to 0.

Structure
REQ-030 Package exc_pkg shall hold ExcCode constants, exc_vec bit indices, FSM state enum, and the EXC_ENTER_ADDR default.
REQ-031 Sub-module exc_prio_enc (combinational: int_q, exc_vec, eret -> winner, code, badvaddr select) shall be instantiated once.

Verification
REQ-032 syscall at wb_pc=0xBFC00100, delay_slot=0 -> trig+1 cancel=1, code 0x08, exc_epc 0xBFC00100, set_exl=1; trig+2 redirect_pc 0xBFC00380.
REQ-033 raddr_error, dm_addr=0x80000003, delay_slot=1, wb_pc=0xBFC00204 -> code 0x04, exc_bd=1, exc_epc 0xBFC00200, badvaddr_we=1, exc_badvaddr 0x80000003.
REQ-034 eret with epc=0xBFC00500 and overflow same instr -> overflow wins, code 0x0C, set_exl=1, redirect 0xBFC00380; eret alone -> clr_exl=1, redirect 0xBFC00500.
REQ-035 int_pending=0x80, status_im=0x80, ie=1, exl=0 -> int taken on next wb_valid, code 0x00; exl=1 -> no trigger.
REQ-036 Hold redirect_ack=0 for 5 cycles -> redirect_valid/pc stable, busy=1, new triggers ignored; assert resetn=0 mid-REDIRECT -> all outputs 0 at once; with EXC_CTRL_STATS_EN, count equals taken exceptions.
